// File: rtl/id2ex_skid.sv
// Decode-to-execute pipeline boundary: a two-entry skid buffer with a registered InReady,
// flush on redirect, bubble gating of the outgoing bundle and a back-pressure cycle counter.
module id2ex_skid #(
    parameter int unsigned PAYLOAD_W = 420,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [PAYLOAD_W-1:0] InPayload,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [PAYLOAD_W-1:0] OutPayload,
    input  logic                 Flush,
    output logic [CNT_W-1:0]     StallCnt
);

    // Occupancy is fully encoded by the two valid bits; this enum only names it for the case.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    logic                 mainValidQ, mainValidD;
    logic                 skidValidQ, skidValidD;
    logic [PAYLOAD_W-1:0] mainPayloadQ, mainPayloadD;
    logic [PAYLOAD_W-1:0] skidPayloadQ, skidPayloadD;
    logic [CNT_W-1:0]     stallCntQ, stallCntD;

    state_e state;
    logic   inFire;
    logic   outFire;
    logic   stall;

    // Handshake decode; InReady comes straight from a flop so there is no path from OutReady.
    always_comb begin
        state   = skidValidQ ? StFull : (mainValidQ ? StOne : StEmpty);
        inFire  = InValid & ~skidValidQ;
        outFire = mainValidQ & OutReady;
        stall   = mainValidQ & ~OutReady;
    end

    // Next-state for the two entries; Flush overrides any same-cycle transfer.
    always_comb begin
        mainValidD   = mainValidQ;
        skidValidD   = skidValidQ;
        mainPayloadD = mainPayloadQ;
        skidPayloadD = skidPayloadQ;
        if (Flush) begin
            // Payload regs are left alone; output gating hides stale data.
            mainValidD = 1'b0;
            skidValidD = 1'b0;
        end else begin
            unique case (state)
                StEmpty: begin
                    if (inFire) begin
                        mainValidD   = 1'b1;
                        mainPayloadD = InPayload;
                    end
                end
                StOne: begin
                    if (inFire && outFire) begin
                        mainPayloadD = InPayload;
                    end else if (inFire) begin
                        skidValidD   = 1'b1;
                        skidPayloadD = InPayload;
                    end else if (outFire) begin
                        mainValidD = 1'b0;
                    end
                end
                StFull: begin
                    if (outFire) begin
                        mainPayloadD = skidPayloadQ;
                        skidValidD   = 1'b0;
                    end
                end
                default: begin
                    mainValidD = 1'b0;
                    skidValidD = 1'b0;
                end
            endcase
        end
    end

    // Stall counter: free-running wrap, untouched by Flush.
    always_comb begin
        stallCntD = stallCntQ;
        if (stall) begin
            stallCntD = stallCntQ + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            mainValidQ   <= 1'b0;
            skidValidQ   <= 1'b0;
            mainPayloadQ <= '0;
            skidPayloadQ <= '0;
            stallCntQ    <= '0;
        end else begin
            mainValidQ   <= mainValidD;
            skidValidQ   <= skidValidD;
            mainPayloadQ <= mainPayloadD;
            skidPayloadQ <= skidPayloadD;
            stallCntQ    <= stallCntD;
        end
    end

    // Outputs; an empty boundary presents the all-zero NOP bundle.
    always_comb begin
        InReady    = ~skidValidQ;
        OutValid   = mainValidQ;
        OutPayload = mainPayloadQ & {PAYLOAD_W{mainValidQ}};
        StallCnt   = stallCntQ;
    end

endmodule

// File: tb/tb_id2ex_skid.sv
// Directed bench for id2ex_skid: a vector table for streaming, back-pressure and flush,
// hand sequences for async reset mid-stall and counter wrap (narrow-counter instance).
module tb_id2ex_skid;

    localparam int unsigned PW = 420;
    localparam int unsigned NV = 24;

    logic          Clk;
    logic          Rst;
    logic          InValid;
    logic          InReady;
    logic [PW-1:0] InPayload;
    logic          OutValid;
    logic          OutReady;
    logic [PW-1:0] OutPayload;
    logic          Flush;
    logic [31:0]   StallCnt;

    // Second instance with a 4-bit counter so wrap-around is reachable.
    logic          wInValid;
    logic          wInReady;
    logic          wOutValid;
    logic          wOutReady;
    logic [PW-1:0] wOutPayload;
    logic [3:0]    wStallCnt;

    int checks = 0;
    int failures = 0;

    id2ex_skid #(.PAYLOAD_W(PW), .CNT_W(32)) dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady), .InPayload(InPayload),
        .OutValid(OutValid), .OutReady(OutReady), .OutPayload(OutPayload), .Flush(Flush),
        .StallCnt(StallCnt)
    );

    id2ex_skid #(.PAYLOAD_W(PW), .CNT_W(4)) dutW (
        .Clk(Clk), .Rst(Rst), .InValid(wInValid), .InReady(wInReady), .InPayload(InPayload),
        .OutValid(wOutValid), .OutReady(wOutReady), .OutPayload(wOutPayload), .Flush(1'b0),
        .StallCnt(wStallCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        inV;
        logic        oR;
        logic        fl;
        logic [63:0] inAddr;
        logic        expOV;
        logic        expIR;
        logic [63:0] expAddr;
        logic [31:0] expStall;
    } vec_t;

    vec_t vecs[NV];

    // Bundle with InstAddr, Imm=~addr, RdWriteEnable and MRetEnable set so all regions toggle.
    function automatic logic [PW-1:0] mk(input logic [63:0] addr);
        logic [PW-1:0] p;
        p = '0;
        p[63:0]    = addr;
        p[255:192] = ~addr;
        p[284]     = 1'b1;
        p[419]     = 1'b1;
        return p;
    endfunction

    function automatic vec_t v(input logic inV, input logic oR, input logic fl,
                               input logic [63:0] inAddr, input logic expOV, input logic expIR,
                               input logic [63:0] expAddr, input logic [31:0] expStall);
        vec_t r;
        r.inV = inV; r.oR = oR; r.fl = fl; r.inAddr = inAddr;
        r.expOV = expOV; r.expIR = expIR; r.expAddr = expAddr; r.expStall = expStall;
        return r;
    endfunction

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock edge, then sample 1 time unit later.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chkState(input string tag, input logic ov, input logic ir,
                            input logic [PW-1:0] pay, input logic [31:0] st);
        chk({tag, ".OutValid"}, PW'(OutValid), PW'(ov));
        chk({tag, ".InReady"}, PW'(InReady), PW'(ir));
        chk({tag, ".OutPayload"}, OutPayload, pay);
        chk({tag, ".StallCnt"}, PW'(StallCnt), PW'(st));
    endtask

    initial begin
        // Streaming: 8 bundles, one per cycle, each visible right after its accepting edge.
        for (int i = 0; i < 8; i++) begin
            vecs[i] = v(1, 1, 0, 64'h8000_0000 + 64'(4 * i), 1, 1, 64'h8000_0000 + 64'(4 * i), 0);
        end
        vecs[8]  = v(0, 1, 0, 0,        0, 1, 0,        0);
        // Back-pressure: A then B into FULL, InValid keeps changing while InReady=0.
        vecs[9]  = v(1, 0, 0, 64'h1000, 1, 1, 64'h1000, 0);
        vecs[10] = v(1, 0, 0, 64'h2000, 1, 0, 64'h1000, 1);
        vecs[11] = v(1, 0, 0, 64'h3000, 1, 0, 64'h1000, 2);
        vecs[12] = v(1, 0, 0, 64'h3004, 1, 0, 64'h1000, 3);
        vecs[13] = v(0, 0, 0, 64'h3008, 1, 0, 64'h1000, 4);
        vecs[14] = v(0, 0, 0, 0,        1, 0, 64'h1000, 5);
        vecs[15] = v(0, 1, 0, 0,        1, 1, 64'h2000, 5);
        vecs[16] = v(0, 1, 0, 0,        0, 1, 0,        5);
        // Flush collision from FULL with in_fire-looking input and OutReady=1.
        vecs[17] = v(1, 0, 0, 64'h5000, 1, 1, 64'h5000, 5);
        vecs[18] = v(1, 0, 0, 64'h6000, 1, 0, 64'h5000, 6);
        vecs[19] = v(1, 1, 1, 64'h7000, 0, 1, 0,        6);
        vecs[20] = v(0, 1, 0, 0,        0, 1, 0,        6);
        // Flush in ONE while stalling: counter still counts that cycle; incoming bundle dropped.
        vecs[21] = v(1, 0, 0, 64'h9000, 1, 1, 64'h9000, 6);
        vecs[22] = v(1, 0, 1, 64'hA000, 0, 1, 0,        7);
        vecs[23] = v(0, 0, 0, 0,        0, 1, 0,        7);

        Rst = 1'b0; InValid = 1'b0; InPayload = '0; OutReady = 1'b0; Flush = 1'b0;
        wInValid = 1'b0; wOutReady = 1'b0;

        // Reset / idle.
        #2;
        chkState("reset_held", 0, 1, '0, 0);
        step();
        Rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chkState("idle", 0, 1, '0, 0);
        end

        // Vector table.
        for (int i = 0; i < NV; i++) begin
            InValid   = vecs[i].inV;
            OutReady  = vecs[i].oR;
            Flush     = vecs[i].fl;
            InPayload = mk(vecs[i].inAddr);
            step();
            chkState($sformatf("vec%0d", i), vecs[i].expOV, vecs[i].expIR,
                     vecs[i].expOV ? mk(vecs[i].expAddr) : '0, vecs[i].expStall);
        end

        // Async reset mid-stall: clear counter, build FULL with StallCnt=3, then pull Rst.
        InValid = 1'b0; OutReady = 1'b0; Flush = 1'b0;
        Rst = 1'b0;
        #1;
        chkState("rst_pulse", 0, 1, '0, 0);
        Rst = 1'b1;
        InValid = 1'b1; InPayload = mk(64'hB000);
        step();
        InPayload = mk(64'hC000);
        step();
        InValid = 1'b0;
        step();
        step();
        chkState("pre_async", 1, 0, mk(64'hB000), 3);
        #2;
        Rst = 1'b0;
        #1;
        chkState("async_rst", 0, 1, '0, 0);
        step();
        Rst = 1'b1;
        step();
        chkState("post_async", 0, 1, '0, 0);

        // Counter wrap on the 4-bit instance: 15 stalls to all-ones, one more to zero.
        wInValid = 1'b1; wOutReady = 1'b0;
        step();
        wInValid = 1'b0;
        chk("wrap_start", PW'(wStallCnt), PW'(0));
        for (int i = 0; i < 15; i++) step();
        chk("wrap_allones", PW'(wStallCnt), PW'(4'hF));
        chk("wrap_outvalid", PW'(wOutValid), PW'(1));
        step();
        chk("wrap_zero", PW'(wStallCnt), PW'(0));
        wOutReady = 1'b1;
        step();
        chk("wrap_drain", PW'(wOutValid), PW'(0));
        chk("wrap_drain_ready", PW'(wInReady), PW'(1));
        chk("wrap_drain_payload", wOutPayload, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
